// File: rtl/calc_if.sv
// Purpose: keypad buttons, arithmetic-unit handshake and control outputs of the calculator sequencer.
// Latency: none, this is only a bundle of wires.
// Backpressure: none. The master drives buttons and DONE. The slave drives the control pulses and status.
interface calc_if;
    logic       Enter;
    logic       Add;
    logic       Sub;
    logic       Mul;
    logic       Div;
    logic       DONE;
    logic       LdA;
    logic       LdB;
    logic       START_MUL;
    logic       START_DIV;
    logic [3:0] OP;
    logic       DISP_RES;
    logic       BUSY;
    logic       ERR;

    modport master (
        output Enter, Add, Sub, Mul, Div, DONE,
        input  LdA, LdB, START_MUL, START_DIV, OP, DISP_RES, BUSY, ERR
    );

    modport slave (
        input  Enter, Add, Sub, Mul, Div, DONE,
        output LdA, LdB, START_MUL, START_DIV, OP, DISP_RES, BUSY, ERR
    );
endinterface

// File: rtl/calc_sequencer.sv
// Purpose: calculator control FSM. It takes operand entry, op latching and mul/div launch, with a timeout.
// Latency: a button edge produces the LdA/LdB pulse in the next cycle. START_* follows LdB by one cycle.
// Backpressure: none. Presses that arrive where they are not accepted are dropped and never queued.
module calc_sequencer #(
    parameter int unsigned TIMEOUT = 200
) (
    input  logic  CLK,
    input  logic  CLR,
    calc_if.slave bus
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_EXEC = 3'd2,
        S_WAIT = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0100;
    localparam logic [3:0] OP_DIV  = 4'b1000;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    // Button vector order: {Enter, Add, Sub, Mul, Div}
    localparam int B_ENT = 4;
    localparam int B_ADD = 3;
    localparam int B_SUB = 2;
    localparam int B_MUL = 1;
    localparam int B_DIV = 0;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] prev_q, prev_d;
    logic       lda_q, lda_d;
    logic       ldb_q, ldb_d;
    logic       smul_q, smul_d;
    logic       sdiv_q, sdiv_d;

    logic [4:0] btn;
    logic [4:0] press;
    logic [3:0] op_sel;
    logic [7:0] cnt_inc;

    assign btn     = {bus.Enter, bus.Add, bus.Sub, bus.Mul, bus.Div};
    assign press   = btn & ~prev_q;
    assign cnt_inc = cnt_q + 8'd1;

    // Simultaneous op presses collapse to one op: Add > Sub > Mul > Div
    always_comb begin
        op_sel = OP_NONE;
        if (press[B_ADD])      op_sel = OP_ADD;
        else if (press[B_SUB]) op_sel = OP_SUB;
        else if (press[B_MUL]) op_sel = OP_MUL;
        else if (press[B_DIV]) op_sel = OP_DIV;
    end

    // Next-state logic. The pulses default low, so each pulse lasts one cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        prev_d  = btn;
        lda_d   = 1'b0;
        ldb_d   = 1'b0;
        smul_d  = 1'b0;
        sdiv_d  = 1'b0;
        case (state_q)
            S_A: begin
                if (op_sel != OP_NONE) begin
                    op_d    = op_sel;
                    lda_d   = 1'b1;
                    state_d = S_B;
                end
            end
            S_B: begin
                // A new op in the same cycle as Enter is latched first, so Enter executes the newest op
                if (op_sel != OP_NONE) begin
                    op_d = op_sel;
                end
                if (press[B_ENT]) begin
                    ldb_d   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = 8'd0;
                if (op_q == OP_MUL) begin
                    smul_d  = 1'b1;
                    state_d = S_WAIT;
                end else if (op_q == OP_DIV) begin
                    sdiv_d  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    state_d = S_SHOW;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // DONE wins over a timeout that lands in the same cycle
                if (bus.DONE) begin
                    state_d = S_SHOW;
                end else if (cnt_inc == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (press[B_ENT]) begin
                    op_d    = OP_NONE;
                    err_d   = 1'b0;
                    state_d = S_A;
                end
            end
            default: begin
                state_d = S_A;
            end
        endcase
    end

    // State and output registers. Reset holds the previous-value registers at 1 so that held buttons stay quiet.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= S_A;
            op_q    <= OP_NONE;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
            prev_q  <= '1;
            lda_q   <= 1'b0;
            ldb_q   <= 1'b0;
            smul_q  <= 1'b0;
            sdiv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            lda_q   <= lda_d;
            ldb_q   <= ldb_d;
            smul_q  <= smul_d;
            sdiv_q  <= sdiv_d;
        end
    end

    assign bus.LdA       = lda_q;
    assign bus.LdB       = ldb_q;
    assign bus.START_MUL = smul_q;
    assign bus.START_DIV = sdiv_q;
    assign bus.OP        = op_q;
    assign bus.ERR       = err_q;
    assign bus.DISP_RES  = (state_q == S_SHOW);
    assign bus.BUSY      = (state_q == S_EXEC) || (state_q == S_WAIT);

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 200, maximum cycles to wait for DONE after a START_MUL/START_DIV pulse (legal range 1..255).
REQ-002 CLK  input  1  single system clock; all state changes on rising edge.
REQ-003 CLR  input  1  reset; synchronous, active-high.
REQ-004 Enter  input  1  level button, one action per rising level.
REQ-005 Add, Sub, Mul, Div  input  1 each  level op buttons, one action per rising level.
REQ-006 DONE  input  1  arithmetic unit mul/div completion, sampled in S_WAIT only.
REQ-007 LdA  output  1  registered one-cycle pulse, load operand A from keypad.
REQ-008 LdB  output  1  registered one-cycle pulse, load operand B from keypad.
REQ-009 START_MUL, START_DIV  output  1 each  registered one-cycle pulses, launch multi-cycle mul/div.
REQ-010 OP  output  4  latched operation: 0001 add, 0010 sub, 0100 mul, 1000 div, 0000 none.
REQ-011 DISP_RES  output  1  display select: 0 = live keypad value, 1 = arithmetic result.
REQ-012 BUSY  output  1  high while an operation is executing.
REQ-013 ERR  output  1  high when a mul/div operation timed out.

Function
REQ-014 Each button SHALL have a previous-value register; press = input high AND previous low, evaluated at each clock edge; a held button SHALL yield exactly one press.
REQ-015 Simultaneous op presses SHALL resolve by priority Add > Sub > Mul > Div; lower-priority simultaneous presses SHALL be discarded.
REQ-016 States: S_A (entering A), S_B (entering B), S_EXEC, S_WAIT, S_SHOW.
REQ-017 S_A: op press -> latch OP, pulse LdA, go S_B; Enter press ignored.
REQ-018 S_B: op press -> replace OP, no LdA/LdB pulse, stay S_B; Enter press -> pulse LdB, go S_EXEC.
REQ-019 S_EXEC (one cycle): OP add/sub -> go S_SHOW; OP mul -> pulse START_MUL, go S_WAIT; OP div -> pulse START_DIV, go S_WAIT; timeout counter loaded with 0.
REQ-020 S_WAIT: counter increments each cycle; DONE high -> go S_SHOW, ERR stays 0; counter reaching TIMEOUT with DONE low -> ERR set, go S_SHOW.
REQ-021 DONE and timeout in the same cycle SHALL resolve as DONE (ERR stays 0).
REQ-022 S_SHOW: Enter press -> OP cleared to 0000, ERR cleared, go S_A; op presses ignored.
REQ-023 All presses during S_EXEC and S_WAIT SHALL be ignored (not queued).
REQ-024 Output pulses SHALL be asserted for exactly the one cycle following the edge at which the causing transition is taken; no two of LdA, LdB, START_MUL, START_DIV high in the same cycle.
REQ-025 Latency: press edge -> LdA/LdB high next cycle; Enter in S_B -> LdB at cycle k+1, START_* at cycle k+2, BUSY high cycles k+1 through exit of S_WAIT.
REQ-026 DISP_RES SHALL be 1 exactly while in S_SHOW; BUSY SHALL be 1 exactly while in S_EXEC or S_WAIT.
REQ-027 DONE outside S_WAIT SHALL be ignored.

Reset
REQ-028 CLR high at a clock edge SHALL force S_A, OP = 0000, LdA = LdB = START_MUL = START_DIV = 0, DISP_RES = 0, BUSY = 0, ERR = 0, counter = 0, from any state including S_WAIT.
REQ-029 Previous-value registers SHALL load 1 during reset, so a button held through reset release produces no press.
REQ-030 CLR SHALL take precedence over every press and DONE in the same cycle.

Verification
REQ-031 Add path: Add press in S_A -> LdA one cycle, OP = 0001; Enter -> LdB one cycle, BUSY one cycle, DISP_RES = 1, no START pulse.
REQ-032 Mul path: Mul, Enter, DONE asserted 5 cycles after START_MUL -> exactly one START_MUL, BUSY high until DONE, S_SHOW with ERR = 0.
REQ-033 Div timeout with TIMEOUT = 10, DONE never asserted -> ERR = 1, DISP_RES = 1 after 10 wait cycles; Enter -> ERR = 0, OP = 0000, S_A.
REQ-034 Add and Div pressed in the same cycle in S_A -> OP = 0001; Sub pressed in S_B -> OP = 0010, no extra LdA.
REQ-035 Enter held high 20 cycles in S_B -> single LdB; Mul pressed during S_WAIT -> no effect.
REQ-036 CLR asserted mid S_WAIT with Enter held through release -> all outputs at reset values, S_A, no press generated after release.
